sd_card_cmd_responder: RTL and testbench
========================================

# sd_card_cmd_responder

Card-side model of the SD CMD line in 1-bit SD bus mode. It receives the 48-bit host commands clocked by the host's SDCLK, checks the CRC7 and decodes CMD0, CMD8 and CMD55. It answers with R7 or R1 48-bit responses after a programmable NCR gap. It sits opposite the SD host sequencer, either in the simulation bench or on a second FPGA port as a card emulator. The top level wraps `cmd_o`/`cmd_oe_o` in an IOBUF with T = ~cmd_oe_o.

## Interface
Parameters:
- NCR, 2: SDCLK cycles from the command end bit to the response start bit. Legal range 2..64.

Ports:
- clk_i  input  1  system clock; must be at least 8x SDCLK.
- rst_i  input  1  synchronous, active-high reset.
- sdclk_i  input  1  host SDCLK (asynchronous).
- cmd_i  input  1  CMD line as seen at the pad (asynchronous).
- cmd_o  output  1  CMD value to drive.
- cmd_oe_o  output  1  1 = drive CMD.
- cmd_valid_o  output  1  1-clk pulse: a command passed all checks.
- cmd_index_o  output  6  index of the last valid command.
- cmd_arg_o  output  32  argument of the last valid command.
- crc_err_o  output  1  1-clk pulse: CRC7 or end-bit failure.

## Operation
- **Input synchronisation.** `sdclk_i` and `cmd_i` each pass through a 2-flop synchroniser. SDCLK rise/fall are single-clk strobes taken from the synchronised SDCLK and its previous value.
- **CRC7.** Polynomial x^7+x^3+1, initial value 0, computed MSB-first over bits 47..8. The same engine serves RX check and TX generation.
- **Status register** (32 bits, reported in R1):
  - Bit 8 READY_FOR_DATA is constant 1.
  - CURRENT_STATE [12:9] is constant 0.
  - Bit 5 APP_CMD.
  - Bit 22 ILLEGAL_COMMAND.
  - Bit 23 COM_CRC_ERROR.
- **FSM states:**
  - IDLE: on an SDCLK rise with CMD = 0, go to RECV with the bit count at 1.
  - RECV: shift CMD on each SDCLK rise. After 48 bits total, go to DECODE.
  - DECODE (1 clk):
    - Bit 46 (transmission bit) = 0: go to IDLE silently.
    - CRC mismatch or end bit != 1: pulse crc_err_o, set bit 23, go to IDLE with no response.
    - Otherwise pulse cmd_valid_o, latch index and argument, then dispatch:
      - CMD0: clear status bits 5/22/23, go to IDLE with no response.
      - CMD8: build R7 = {0,0,001000, arg[31:12]=0 echoed, arg[11:8], arg[7:0], CRC7, 1}, go to NCR.
      - CMD55: set bit 5, build R1 = {0,0,110111, status, CRC7, 1}, go to NCR.
      - Any other index: set bit 22, clear bit 5, go to IDLE with no response.
  - NCR: count SDCLK falls. On the NCR-th fall, assert cmd_oe_o with cmd_o = response bit 47, then go to SEND.
  - SEND: each SDCLK fall shifts the next bit out. The fall after bit 0 (the end bit) has been held for one period deasserts cmd_oe_o and returns to IDLE.
- **After an R1 is built:** clear bits 22/23 (report once). APP_CMD is cleared by any valid command other than CMD55.
- **CMD input** is ignored in NCR and SEND.

## Timing
- Reset values:
  - cmd_o = 1.
  - cmd_oe_o = 0.
  - cmd_valid_o = 0, crc_err_o = 0.
  - cmd_index_o = 0, cmd_arg_o = 0.
  - Status = 0x00000100.
  - State IDLE, all counters 0.
- Sampling and driving edges: command bits are sampled on SDCLK rise + 3 clk (synchroniser + edge detect). Response bits change on SDCLK fall + 3 clk.
- DECODE pulses (cmd_valid_o, crc_err_o) occur 1 clk after the 48th sampled rise.
- The response start bit is driven exactly NCR SDCLK falls after the command end bit was sampled.
- rst_i high mid-RECV or mid-SEND: on the next clk, cmd_oe_o = 0 and all state returns to reset values. A partial command is discarded.
- An SDCLK rise during DECODE cannot be lost: DECODE lasts 1 clk, and clk_i is at least 8x SDCLK.
- NCR outside 2..64 is an elaboration error.

## Test plan
- CMD0 0x400000000095 → cmd_valid_o pulse, index 0, no cmd_oe_o assertion within 64 SDCLK.
- CMD8 0x48000001AA87 → cmd_arg_o = 0x000001AA; response 0x08000001AA13 starts 2 SDCLK after the end bit; cmd_oe_o drops one period after the end bit.
- CMD55 0x770000000065 → response 0x370000012083 (status 0x00000120).
- CMD8 with a corrupted CRC (0x48000001AA89) → crc_err_o pulse, no response. The following CMD55 response has status 0x00800120 with a correct CRC7 from the bench model. The next CMD55 after that returns 0x00000120.
- CMD2 0x4200000000xx (valid CRC) → no response. The next CMD55 reports status 0x00400120.
- rst_i asserted during SEND bit 20 → cmd_oe_o = 0 on the next clk. After reset release, CMD8 is answered correctly with NCR = 2, and NCR = 64 is also exercised.

Source files
------------

// File: rtl/sd_card_cmd_responder_if.sv
// CMD-line bundle between an SD host (master) and the card-side responder (slave).
// Signal names keep the card's pin naming so the pad wrapper maps one-to-one.
interface sd_card_cmd_responder_if;
    localparam int unsigned IDX_W = 6;
    localparam int unsigned ARG_W = 32;

    logic             sdclk_i;
    logic             cmd_i;
    logic             cmd_o;
    logic             cmd_oe_o;
    logic             cmd_valid_o;
    logic [IDX_W-1:0] cmd_index_o;
    logic [ARG_W-1:0] cmd_arg_o;
    logic             crc_err_o;

    modport master (
        output sdclk_i, cmd_i,
        input  cmd_o, cmd_oe_o, cmd_valid_o, cmd_index_o, cmd_arg_o, crc_err_o
    );

    modport slave (
        input  sdclk_i, cmd_i,
        output cmd_o, cmd_oe_o, cmd_valid_o, cmd_index_o, cmd_arg_o, crc_err_o
    );
endinterface

// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD-line responder: receives 48-bit commands, checks CRC7,
// decodes CMD0/CMD8/CMD55 and answers R7/R1 after an NCR gap of SDCLK falls.
module sd_card_cmd_responder #(
    parameter int unsigned NCR = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    sd_card_cmd_responder_if.slave      sd
);
    localparam int unsigned FRAME_W   = 48;
    localparam int unsigned PAYLOAD_W = 40;
    localparam int unsigned CRC_W     = 7;
    localparam int unsigned IDX_W     = 6;
    localparam int unsigned ARG_W     = 32;
    localparam int unsigned CNT_W     = 7;

    localparam logic [IDX_W-1:0] IDX_CMD0  = 6'd0;
    localparam logic [IDX_W-1:0] IDX_CMD8  = 6'd8;
    localparam logic [IDX_W-1:0] IDX_CMD55 = 6'd55;

    generate
        if ((NCR < 2) || (NCR > 64)) begin : g_ncr_range
            $error("sd_card_cmd_responder: NCR must be within 2..64");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_DECODE,
        S_NCR,
        S_SEND
    } state_t;

    // MSB-first CRC7, x^7+x^3+1, zero seed; shared by RX check and TX build.
    function automatic logic [CRC_W-1:0] crc7(input logic [PAYLOAD_W-1:0] data);
        logic [CRC_W-1:0] c;
        logic             fb;
        c = '0;
        for (int i = PAYLOAD_W - 1; i >= 0; i--) begin
            fb = data[i] ^ c[CRC_W-1];
            c  = {c[CRC_W-2:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    logic sdclk_s1, sdclk_s2, sdclk_d;
    logic cmd_s1, cmd_s2;
    logic sd_rise, sd_fall;

    state_t             state, state_n;
    logic [FRAME_W-1:0] sr, sr_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               app_q, app_n;
    logic               ill_q, ill_n;
    logic               ccrc_q, ccrc_n;
    logic               cmd_o_q, cmd_o_n;
    logic               oe_q, oe_n;
    logic               valid_q, valid_n;
    logic               crc_err_q, crc_err_n;
    logic [IDX_W-1:0]   idx_q, idx_n;
    logic [ARG_W-1:0]   arg_q, arg_n;

    logic [ARG_W-1:0]     status_word;
    logic [ARG_W-1:0]     status_r1;
    logic [CRC_W-1:0]     rx_crc;
    logic [PAYLOAD_W-1:0] resp_payload;
    logic [CRC_W-1:0]     resp_crc;

    // Two-flop synchronisers; CMD idles high so it resets to 1.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sdclk_s1 <= 1'b0;
            sdclk_s2 <= 1'b0;
            sdclk_d  <= 1'b0;
            cmd_s1   <= 1'b1;
            cmd_s2   <= 1'b1;
        end else begin
            sdclk_s1 <= sd.sdclk_i;
            sdclk_s2 <= sdclk_s1;
            sdclk_d  <= sdclk_s2;
            cmd_s1   <= sd.cmd_i;
            cmd_s2   <= cmd_s1;
        end
    end

    assign sd_rise = sdclk_s2 & ~sdclk_d;
    assign sd_fall = ~sdclk_s2 & sdclk_d;

    assign status_word = {8'h00, ccrc_q, ill_q, 13'h0000, 1'b1, 2'b00, app_q, 5'h00};

    // Response payload: R7 echoes check pattern/VHS, R1 reports status with APP_CMD set.
    always_comb begin
        status_r1    = status_word;
        status_r1[5] = 1'b1;
        if (sr[45:40] == IDX_CMD8) begin
            resp_payload = {2'b00, IDX_CMD8, 20'h00000, sr[19:8]};
        end else begin
            resp_payload = {2'b00, IDX_CMD55, status_r1};
        end
    end

    assign rx_crc   = crc7(sr[FRAME_W-1:CRC_W+1]);
    assign resp_crc = crc7(resp_payload);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= S_IDLE;
            sr        <= '0;
            cnt       <= '0;
            app_q     <= 1'b0;
            ill_q     <= 1'b0;
            ccrc_q    <= 1'b0;
            cmd_o_q   <= 1'b1;
            oe_q      <= 1'b0;
            valid_q   <= 1'b0;
            crc_err_q <= 1'b0;
            idx_q     <= '0;
            arg_q     <= '0;
        end else begin
            state     <= state_n;
            sr        <= sr_n;
            cnt       <= cnt_n;
            app_q     <= app_n;
            ill_q     <= ill_n;
            ccrc_q    <= ccrc_n;
            cmd_o_q   <= cmd_o_n;
            oe_q      <= oe_n;
            valid_q   <= valid_n;
            crc_err_q <= crc_err_n;
            idx_q     <= idx_n;
            arg_q     <= arg_n;
        end
    end

    always_comb begin
        state_n   = state;
        sr_n      = sr;
        cnt_n     = cnt;
        app_n     = app_q;
        ill_n     = ill_q;
        ccrc_n    = ccrc_q;
        cmd_o_n   = cmd_o_q;
        oe_n      = oe_q;
        valid_n   = 1'b0;
        crc_err_n = 1'b0;
        idx_n     = idx_q;
        arg_n     = arg_q;

        unique case (state)
            S_IDLE: begin
                if (sd_rise && !cmd_s2) begin
                    state_n = S_RECV;
                    sr_n    = '0;
                    cnt_n   = CNT_W'(1);
                end
            end
            S_RECV: begin
                if (sd_rise) begin
                    sr_n  = {sr[FRAME_W-2:0], cmd_s2};
                    cnt_n = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(FRAME_W - 1)) state_n = S_DECODE;
                end
            end
            S_DECODE: begin
                state_n = S_IDLE;
                cnt_n   = '0;
                if (!sr[46]) begin
                    // Not host-originated: drop without any indication.
                end else if ((rx_crc != sr[CRC_W:1]) || !sr[0]) begin
                    crc_err_n = 1'b1;
                    ccrc_n    = 1'b1;
                end else begin
                    valid_n = 1'b1;
                    idx_n   = sr[45:40];
                    arg_n   = sr[39:8];
                    case (sr[45:40])
                        IDX_CMD0: begin
                            app_n  = 1'b0;
                            ill_n  = 1'b0;
                            ccrc_n = 1'b0;
                        end
                        IDX_CMD8: begin
                            app_n   = 1'b0;
                            sr_n    = {resp_payload, resp_crc, 1'b1};
                            state_n = S_NCR;
                        end
                        IDX_CMD55: begin
                            // Error bits are reported once, in this R1.
                            app_n   = 1'b1;
                            ill_n   = 1'b0;
                            ccrc_n  = 1'b0;
                            sr_n    = {resp_payload, resp_crc, 1'b1};
                            state_n = S_NCR;
                        end
                        default: begin
                            ill_n = 1'b1;
                            app_n = 1'b0;
                        end
                    endcase
                end
            end
            S_NCR: begin
                if (sd_fall) begin
                    if (cnt == CNT_W'(NCR - 1)) begin
                        oe_n    = 1'b1;
                        cmd_o_n = sr[FRAME_W-1];
                        sr_n    = {sr[FRAME_W-2:0], 1'b1};
                        cnt_n   = CNT_W'(FRAME_W - 1);
                        state_n = S_SEND;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            S_SEND: begin
                // cnt holds bits still to drive; at zero the end bit has had its period.
                if (sd_fall) begin
                    if (cnt == '0) begin
                        oe_n    = 1'b0;
                        cmd_o_n = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        cmd_o_n = sr[FRAME_W-1];
                        sr_n    = {sr[FRAME_W-2:0], 1'b1};
                        cnt_n   = cnt - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign sd.cmd_o       = cmd_o_q;
    assign sd.cmd_oe_o    = oe_q;
    assign sd.cmd_valid_o = valid_q;
    assign sd.crc_err_o   = crc_err_q;
    assign sd.cmd_index_o = idx_q;
    assign sd.cmd_arg_o   = arg_q;

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// Directed bench for sd_card_cmd_responder: a host model drives commands on SDCLK
// falls and captures responses on rises; expected frames are constants or model CRCs.
module tb_sd_card_cmd_responder;
    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic sdclk = 1'b0;
    logic host_cmd2  = 1'b1;
    logic host_cmd64 = 1'b1;
    bit   sel = 1'b0;

    int total = 0;
    int bad   = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;
    int oe_cnt    = 0;

    always #5  clk   = ~clk;
    always #80 sdclk = ~sdclk;

    sd_card_cmd_responder_if sd2 ();
    sd_card_cmd_responder_if sd64 ();

    assign sd2.sdclk_i  = sdclk;
    assign sd64.sdclk_i = sdclk;
    assign sd2.cmd_i    = sd2.cmd_oe_o  ? sd2.cmd_o  : host_cmd2;
    assign sd64.cmd_i   = sd64.cmd_oe_o ? sd64.cmd_o : host_cmd64;

    sd_card_cmd_responder #(.NCR(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .sd    (sd2)
    );

    sd_card_cmd_responder #(.NCR(64)) dut64 (
        .clk_i (clk),
        .rst_i (rst),
        .sd    (sd64)
    );

    logic        oe_m, cmd_o_m, valid_m, err_m;
    logic [5:0]  idx_m;
    logic [31:0] arg_m;
    assign oe_m    = sel ? sd64.cmd_oe_o    : sd2.cmd_oe_o;
    assign cmd_o_m = sel ? sd64.cmd_o       : sd2.cmd_o;
    assign valid_m = sel ? sd64.cmd_valid_o : sd2.cmd_valid_o;
    assign err_m   = sel ? sd64.crc_err_o   : sd2.crc_err_o;
    assign idx_m   = sel ? sd64.cmd_index_o : sd2.cmd_index_o;
    assign arg_m   = sel ? sd64.cmd_arg_o   : sd2.cmd_arg_o;

    always @(negedge clk) begin
        if (valid_m) valid_cnt <= valid_cnt + 1;
        if (err_m)   err_cnt   <= err_cnt + 1;
        if (oe_m)    oe_cnt    <= oe_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference CRC7 by polynomial long division of M(x)*x^7 by 0x89.
    function automatic logic [6:0] model_crc7(input logic [39:0] m);
        logic [46:0] r;
        r = {m, 7'h00};
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        end
        return r[6:0];
    endfunction

    function automatic logic [47:0] frame(input logic [39:0] m);
        return {m, model_crc7(m), 1'b1};
    endfunction

    task automatic drive(input logic b);
        if (sel) host_cmd64 = b;
        else     host_cmd2  = b;
    endtask

    task automatic send_cmd(input logic [47:0] c);
        for (int i = 47; i >= 0; i--) begin
            @(negedge sdclk);
            drive(c[i]);
        end
    endtask

    task automatic do_cmd(input string tag, input logic [47:0] c, input bit resp_exp,
                          input logic [47:0] r_exp, input int ncr_exp,
                          input int v_exp, input int e_exp);
        int v0, e0, o0, gap;
        logic [47:0] r;
        v0 = valid_cnt;
        e0 = err_cnt;
        send_cmd(c);
        @(posedge sdclk);
        drive(1'b1);
        if (resp_exp) begin
            gap = 0;
            for (int k = 1; k <= 80; k++) begin
                @(negedge sdclk);
                #50;
                if (oe_m) begin
                    gap = k;
                    break;
                end
            end
            check_eq({tag, "_gap"}, 64'(gap), 64'(ncr_exp));
            if (gap != 0) begin
                r = '0;
                for (int i = 47; i >= 0; i--) begin
                    @(posedge sdclk);
                    #1;
                    r[i] = cmd_o_m;
                end
                check_eq({tag, "_resp"}, 64'(r), 64'(r_exp));
                check_eq({tag, "_oe_end"}, 64'(oe_m), 64'd1);
                @(negedge sdclk);
                #50;
                check_eq({tag, "_oe_drop"}, 64'(oe_m), 64'd0);
            end
        end else begin
            o0 = oe_cnt;
            repeat (64) @(negedge sdclk);
            check_eq({tag, "_no_oe"}, 64'(oe_cnt - o0), 64'd0);
        end
        check_eq({tag, "_valid"}, 64'(valid_cnt - v0), 64'(v_exp));
        check_eq({tag, "_crcerr"}, 64'(err_cnt - e0), 64'(e_exp));
    endtask

    localparam logic [47:0] CMD0     = 48'h4000_0000_0095;
    localparam logic [47:0] CMD8     = 48'h4800_0001_AA87;
    localparam logic [47:0] R7       = 48'h0800_0001_AA13;
    localparam logic [47:0] CMD55    = 48'h7700_0000_0065;
    localparam logic [47:0] R1_OK    = 48'h3700_0001_2083;
    localparam logic [47:0] CMD8_BAD = 48'h4800_0001_AA89;

    initial begin
        #900000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [47:0] cmd2, r1_crc, r1_ill;
        int got;
        cmd2   = frame(40'h42_0000_0000);
        r1_crc = frame(40'h37_0080_0120);
        r1_ill = frame(40'h37_0040_0120);

        rst = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("rst_cmd_o",  64'(sd2.cmd_o), 64'd1);
        check_eq("rst_oe",     64'(sd2.cmd_oe_o), 64'd0);
        check_eq("rst_valid",  64'(sd2.cmd_valid_o), 64'd0);
        check_eq("rst_crcerr", 64'(sd2.crc_err_o), 64'd0);
        check_eq("rst_idx",    64'(sd2.cmd_index_o), 64'd0);
        check_eq("rst_arg",    64'(sd2.cmd_arg_o), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge sdclk);

        sel = 1'b0;
        do_cmd("cmd0", CMD0, 1'b0, 48'h0, 2, 1, 0);
        check_eq("cmd0_idx", 64'(idx_m), 64'd0);

        do_cmd("cmd8", CMD8, 1'b1, R7, 2, 1, 0);
        check_eq("cmd8_idx", 64'(idx_m), 64'd8);
        check_eq("cmd8_arg", 64'(arg_m), 64'h0000_01AA);

        do_cmd("cmd55", CMD55, 1'b1, R1_OK, 2, 1, 0);
        check_eq("cmd55_idx", 64'(idx_m), 64'd55);

        do_cmd("cmd8_bad", CMD8_BAD, 1'b0, 48'h0, 2, 0, 1);
        check_eq("cmd8_bad_idx", 64'(idx_m), 64'd55);
        do_cmd("cmd55_crcflag", CMD55, 1'b1, r1_crc, 2, 1, 0);
        do_cmd("cmd55_clear", CMD55, 1'b1, R1_OK, 2, 1, 0);

        do_cmd("cmd2", cmd2, 1'b0, 48'h0, 2, 1, 0);
        check_eq("cmd2_idx", 64'(idx_m), 64'd2);
        do_cmd("cmd55_illegal", CMD55, 1'b1, r1_ill, 2, 1, 0);

        // Reset while the R7 is being shifted out, around bit 20.
        send_cmd(CMD8);
        @(posedge sdclk);
        drive(1'b1);
        got = 0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge sdclk);
            #50;
            if (oe_m) begin
                got = 1;
                break;
            end
        end
        check_eq("rstsend_oe_seen", 64'(got), 64'd1);
        for (int i = 47; i >= 20; i--) @(posedge sdclk);
        #40;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rstsend_oe",    64'(sd2.cmd_oe_o), 64'd0);
        check_eq("rstsend_cmd_o", 64'(sd2.cmd_o), 64'd1);
        check_eq("rstsend_idx",   64'(sd2.cmd_index_o), 64'd0);
        check_eq("rstsend_arg",   64'(sd2.cmd_arg_o), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge sdclk);
        do_cmd("cmd8_after_rst", CMD8, 1'b1, R7, 2, 1, 0);

        sel = 1'b1;
        repeat (2) @(negedge sdclk);
        do_cmd("cmd8_ncr64", CMD8, 1'b1, R7, 64, 1, 0);
        check_eq("ncr64_arg", 64'(arg_m), 64'h0000_01AA);

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
